nts_api_bridge: RTL and testbench
=================================

// Module: nts_api_bridge
// PURPOSE
//  Host-side front end of the NTS register API, directly upstream of the API address decoder.
//  Accepts one register request at a time on a valid/ready host port and drives the decoder's
//  flat 12-bit cs/we/address/write_data bus.
//  Returns a registered response (read data or write ack, plus unmapped-address error) on a
//  valid/ready response port.
//  Decouples host timing from the combinational decoder and sub-block read latency.
// PARAMETERS
//  READ_LATENCY  1       cycles from first cs cycle to read-data sample point (0..7)
//  ADDR_MAX      12'h1FF highest mapped address; above it no cs is issued, error returned
// PORTS
//  i_clk              in   1   clock
//  i_areset_n         in   1   async active-low reset
//  i_req_valid        in   1   host request valid
//  o_req_ready        out  1   bridge can accept request (IDLE only)
//  i_req_we           in   1   1=write, 0=read
//  i_req_address      in   12  register word address
//  i_req_write_data   in   32  write data
//  o_rsp_valid        out  1   response valid
//  i_rsp_ready        in   1   host accepts response
//  o_rsp_read_data    out  32  captured read data (0 for writes/errors)
//  o_rsp_error        out  1   address > ADDR_MAX
//  o_api_cs           out  1   to decoder chip select
//  o_api_we           out  1   to decoder write enable
//  o_api_address      out  12  to decoder address
//  o_api_write_data   out  32  to decoder write data
//  i_api_read_data    in   32  from decoder read data (valid only while cs high)
// BEHAVIOUR
//  Clock and reset: one clock i_clk; reset is asynchronous, active-low (i_areset_n).
//  Reset values: all outputs 0 except o_req_ready=1; FSM=IDLE; latency counter=0.
//  FSM states: IDLE, ISSUE, WAIT, RESP.
//  IDLE: o_req_ready=1. On i_req_valid, register we/address/write_data.
//   - address<=ADDR_MAX -> ISSUE.
//   - else set error=1, data=0 -> RESP (no cs ever driven).
//  ISSUE: o_api_cs=1, with api bus outputs driven from request registers.
//   - Write: cs high exactly 1 cycle -> RESP, data=0, error=0.
//   - Read, READ_LATENCY=0: sample i_api_read_data this cycle -> RESP.
//   - Read, READ_LATENCY>0: counter=1 -> WAIT.
//  WAIT (reads only): cs, we=0 and address held stable.
//   - Counter increments each cycle.
//   - When counter==READ_LATENCY, sample i_api_read_data in that same cycle -> RESP.
//   - Total cs-high cycles for a read = READ_LATENCY+1. Sub-block reads are side-effect free.
//  RESP: o_api_cs=0; o_rsp_valid=1; rsp data/error held stable until i_rsp_ready.
//   - On handshake -> IDLE, and o_rsp_valid drops next cycle.
//  Throughput: one request in flight.
//   - Ready only in IDLE, so a new request is accepted earliest the cycle after a response
//     handshake.
//   - Write round trip = 3 cycles, with i_rsp_ready held high.
//  o_api_we=0 whenever cs=0. o_api_address/write_data drive 0 in IDLE.
//  i_req_valid while not ready is ignored (no queueing). Request fields are sampled only at
//  the accept edge; later changes have no effect.
//  Reset mid-operation: cs drops asynchronously; the in-flight request is discarded and no
//  response is produced. The host reissues.
//  Counter width: 3 bits. READ_LATENCY>7 is illegal (elaboration-time check).
// STRUCTURE
//  Shared include nts_api_defs.vh holds:
//   - FSM state localparams (2-bit encodings);
//   - ADDR_MAX default;
//   - API address width 12 and data width 32.
//  Flat single module with one FSM and a 3-bit latency counter; no sub-module.
// TESTING
//  1. Write 0xCAFEBABE to 0x010 -> one cs cycle with we=1, addr=0x010, data=0xCAFEBABE;
//     rsp_valid next cycle, data 0, err 0.
//  2. Read 0x003, READ_LATENCY=1, decoder returns 0x12345678 on the 2nd cs cycle -> cs high
//     2 cycles; rsp data 0x12345678.
//  3. Read 0x200 (> ADDR_MAX) -> cs never asserted; rsp_valid with err=1, data=0.
//  4. Hold i_rsp_ready=0 for 5 cycles after rsp_valid -> response stable for 5 cycles;
//     req_ready=0 throughout; new req_valid ignored.
//  5. Assert i_areset_n=0 during WAIT -> cs=0 immediately, req_ready=1 after release,
//     no rsp_valid.
//  6. Back-to-back write then read with ready always high -> second request accepted the
//     cycle after the first response handshake; both responses correct and in order.

Source files
------------

// File: rtl/nts_api_bridge_pkg.sv
// NTS register API bridge: shared widths, address map limit and FSM states.
// Imported by the bridge top and by anything probing its state.
package nts_api_bridge_pkg;

   localparam int unsigned API_AW = 12;
   localparam int unsigned API_DW = 32;

   localparam logic [API_AW-1:0] ADDR_MAX_DEF = 12'h1FF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

endpackage

// File: rtl/nts_api_bridge.sv
// Host-side front end of the NTS register API: one request in flight,
// registered decoder bus and a registered, stall-safe response.
import nts_api_bridge_pkg::*;

module nts_api_bridge #(
   parameter int unsigned       READ_LATENCY = 1,
   parameter logic [API_AW-1:0] ADDR_MAX     = ADDR_MAX_DEF
) (
   input  logic              i_clk,
   input  logic              i_areset_n,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic              i_req_we,
   input  logic [API_AW-1:0] i_req_address,
   input  logic [API_DW-1:0] i_req_write_data,
   output logic              o_rsp_valid,
   input  logic              i_rsp_ready,
   output logic [API_DW-1:0] o_rsp_read_data,
   output logic              o_rsp_error,
   output logic              o_api_cs,
   output logic              o_api_we,
   output logic [API_AW-1:0] o_api_address,
   output logic [API_DW-1:0] o_api_write_data,
   input  logic [API_DW-1:0] i_api_read_data
);

   if (READ_LATENCY > 7) begin : g_bad_latency
      $error("nts_api_bridge: READ_LATENCY must be 0..7");
   end

   localparam logic [2:0] LAT = 3'(READ_LATENCY);

   state_t              r_state;
   logic [2:0]          r_cnt;
   logic                r_req_ready;
   logic                r_rsp_valid;
   logic [API_DW-1:0]   r_rsp_data;
   logic                r_rsp_error;
   logic                r_cs;
   logic                r_we;
   logic [API_AW-1:0]   r_addr;
   logic [API_DW-1:0]   r_wdata;

   logic                w_done;
   logic [API_DW-1:0]   w_data;

   // A write finishes after its single cs cycle; a read when the latency
   // counter reaches READ_LATENCY (immediately for zero latency).
   always_comb begin
      w_done = 1'b0;
      if (r_state == ST_ISSUE)
         w_done = r_we || (LAT == 3'd0);
      else if (r_state == ST_WAIT)
         w_done = (r_cnt == LAT);
      w_data = r_we ? '0 : i_api_read_data;
   end

   always_ff @(posedge i_clk or negedge i_areset_n) begin
      if (!i_areset_n) begin
         r_state     <= ST_IDLE;
         r_cnt       <= 3'd0;
         r_req_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_error <= 1'b0;
         r_cs        <= 1'b0;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (i_req_valid) begin
                  r_req_ready <= 1'b0;
                  if (i_req_address <= ADDR_MAX) begin
                     r_state <= ST_ISSUE;
                     r_cs    <= 1'b1;
                     r_we    <= i_req_we;
                     r_addr  <= i_req_address;
                     r_wdata <= i_req_write_data;
                  end else begin
                     r_state     <= ST_RESP;
                     r_rsp_valid <= 1'b1;
                     r_rsp_error <= 1'b1;
                     r_rsp_data  <= '0;
                  end
               end
            end
            ST_ISSUE, ST_WAIT: begin
               if (w_done) begin
                  r_state     <= ST_RESP;
                  r_cnt       <= 3'd0;
                  r_cs        <= 1'b0;
                  r_we        <= 1'b0;
                  r_addr      <= '0;
                  r_wdata     <= '0;
                  r_rsp_valid <= 1'b1;
                  r_rsp_error <= 1'b0;
                  r_rsp_data  <= w_data;
               end else begin
                  r_state <= ST_WAIT;
                  r_cnt   <= r_cnt + 3'd1;
               end
            end
            ST_RESP: begin
               if (i_rsp_ready) begin
                  r_state     <= ST_IDLE;
                  r_rsp_valid <= 1'b0;
                  r_rsp_error <= 1'b0;
                  r_rsp_data  <= '0;
                  r_req_ready <= 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_req_ready      = r_req_ready;
   assign o_rsp_valid      = r_rsp_valid;
   assign o_rsp_read_data  = r_rsp_data;
   assign o_rsp_error      = r_rsp_error;
   assign o_api_cs         = r_cs;
   assign o_api_we         = r_we;
   assign o_api_address    = r_addr;
   assign o_api_write_data = r_wdata;

endmodule

// File: tb/tb_nts_api_bridge.sv
// Directed bench for nts_api_bridge with READ_LATENCY=1, ADDR_MAX=0x1FF.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_nts_api_bridge;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [11:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic        api_cs;
   logic        api_we;
   logic [11:0] api_addr;
   logic [31:0] api_wdata;
   logic [31:0] api_rdata = '0;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   nts_api_bridge #(.READ_LATENCY(1), .ADDR_MAX(12'h1FF)) dut (
      .i_clk            (clk),
      .i_areset_n       (rst_n),
      .i_req_valid      (req_valid),
      .o_req_ready      (req_ready),
      .i_req_we         (req_we),
      .i_req_address    (req_addr),
      .i_req_write_data (req_wdata),
      .o_rsp_valid      (rsp_valid),
      .i_rsp_ready      (rsp_ready),
      .o_rsp_read_data  (rsp_data),
      .o_rsp_error      (rsp_err),
      .o_api_cs         (api_cs),
      .o_api_we         (api_we),
      .o_api_address    (api_addr),
      .o_api_write_data (api_wdata),
      .i_api_read_data  (api_rdata)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      checks++;
      if ({req_ready, rsp_valid, rsp_err, api_cs, api_we} !== 5'b10000) begin
         errors++;
         $display("FAIL reset_ctl: got %b want 10000",
                  {req_ready, rsp_valid, rsp_err, api_cs, api_we});
      end
      checks++;
      if ({rsp_data, api_addr, api_wdata} !== 76'd0) begin
         errors++;
         $display("FAIL reset_bus: got %h want 0", {rsp_data, api_addr, api_wdata});
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_write();
      req_valid = 1'b1; req_we = 1'b1;
      req_addr = 12'h010; req_wdata = 32'hCAFEBABE;
      tick();
      req_valid = 1'b0; req_addr = 12'h0FF; req_wdata = 32'h0;
      #1;
      checks++;
      if ({api_cs, api_we, req_ready, rsp_valid} !== 4'b1100) begin
         errors++;
         $display("FAIL wr_issue_ctl: got %b want 1100",
                  {api_cs, api_we, req_ready, rsp_valid});
      end
      checks++;
      if (api_addr !== 12'h010 || api_wdata !== 32'hCAFEBABE) begin
         errors++;
         $display("FAIL wr_issue_bus: got %h/%h want 010/cafebabe", api_addr, api_wdata);
      end
      tick();
      checks++;
      if ({api_cs, api_we, rsp_valid, rsp_err} !== 4'b0010 || rsp_data !== 32'h0) begin
         errors++;
         $display("FAIL wr_resp: got %b data %h want 0010 data 0",
                  {api_cs, api_we, rsp_valid, rsp_err}, rsp_data);
      end
      checks++;
      if (api_addr !== 12'h000 || api_wdata !== 32'h0) begin
         errors++;
         $display("FAIL wr_bus_idle: got %h/%h want 0/0", api_addr, api_wdata);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      checks++;
      if ({rsp_valid, req_ready} !== 2'b01) begin
         errors++;
         $display("FAIL wr_handshake: got %b want 01", {rsp_valid, req_ready});
      end
   endtask

   task automatic test_read();
      int cs_cycles = 0;
      req_valid = 1'b1; req_we = 1'b0; req_addr = 12'h003;
      tick();
      req_valid = 1'b0;
      api_rdata = 32'hDEAD0000;
      if (api_cs) cs_cycles++;
      checks++;
      if (api_addr !== 12'h003 || api_we !== 1'b0) begin
         errors++;
         $display("FAIL rd_issue: got addr %h we %b want 003 0", api_addr, api_we);
      end
      tick();
      api_rdata = 32'h12345678;
      if (api_cs) cs_cycles++;
      checks++;
      if (api_addr !== 12'h003 || api_we !== 1'b0 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL rd_wait: got addr %h we %b v %b want 003 0 0",
                  api_addr, api_we, rsp_valid);
      end
      tick();
      api_rdata = 32'h0;
      if (api_cs) cs_cycles++;
      checks++;
      if (cs_cycles !== 2) begin
         errors++;
         $display("FAIL rd_cs_cycles: got %0d want 2", cs_cycles);
      end
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'h12345678 || rsp_err !== 1'b0) begin
         errors++;
         $display("FAIL rd_resp: got v %b data %h err %b want 1 12345678 0",
                  rsp_valid, rsp_data, rsp_err);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   task automatic test_unmapped();
      req_valid = 1'b1; req_we = 1'b1;
      req_addr = 12'h200; req_wdata = 32'hFFFFFFFF;
      tick();
      req_valid = 1'b0;
      checks++;
      if (api_cs !== 1'b0 || rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 32'h0) begin
         errors++;
         $display("FAIL unmapped: got cs %b v %b err %b data %h want 0 1 1 0",
                  api_cs, rsp_valid, rsp_err, rsp_data);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      checks++;
      if (api_cs !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL unmapped_done: got cs %b v %b rdy %b want 0 0 1",
                  api_cs, rsp_valid, req_ready);
      end
   endtask

   task automatic test_stall();
      int bad = 0;
      req_valid = 1'b1; req_we = 1'b0; req_addr = 12'h005;
      tick();
      req_valid = 1'b0;
      tick();
      api_rdata = 32'hA5A55A5A;
      tick();
      api_rdata = 32'h0;
      req_valid = 1'b1; req_we = 1'b1; req_addr = 12'h077; req_wdata = 32'h1;
      for (int i = 0; i < 5; i++) begin
         if (rsp_valid !== 1'b1 || rsp_data !== 32'hA5A55A5A || rsp_err !== 1'b0 ||
             req_ready !== 1'b0 || api_cs !== 1'b0)
            bad++;
         tick();
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL stall_hold: %0d bad cycles want 0", bad);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      tick();
      checks++;
      if (api_cs !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL stall_no_queue: got cs %b rdy %b v %b want 0 1 0",
                  api_cs, req_ready, rsp_valid);
      end
   endtask

   task automatic test_reset_mid();
      int bad = 0;
      req_valid = 1'b1; req_we = 1'b0; req_addr = 12'h006;
      tick();
      req_valid = 1'b0;
      tick();
      checks++;
      if (api_cs !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_pre: got cs %b want 1", api_cs);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (api_cs !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_async: got cs %b rdy %b v %b want 0 1 0",
                  api_cs, req_ready, rsp_valid);
      end
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (api_cs !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL rst_mid_after: %0d bad cycles want 0", bad);
      end
   endtask

   task automatic test_back_to_back();
      rsp_ready = 1'b1;
      req_valid = 1'b1; req_we = 1'b1;
      req_addr = 12'h020; req_wdata = 32'h11112222;
      tick();
      req_we = 1'b0; req_addr = 12'h004; req_wdata = 32'h0;
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'h0 || rsp_err !== 1'b0) begin
         errors++;
         $display("FAIL b2b_rsp1: got v %b data %h err %b want 1 0 0",
                  rsp_valid, rsp_data, rsp_err);
      end
      tick();
      checks++;
      if (req_ready !== 1'b1 || api_cs !== 1'b0 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_idle: got rdy %b cs %b v %b want 1 0 0",
                  req_ready, api_cs, rsp_valid);
      end
      tick();
      req_valid = 1'b0;
      checks++;
      if (api_cs !== 1'b1 || api_we !== 1'b0 || api_addr !== 12'h004) begin
         errors++;
         $display("FAIL b2b_accept2: got cs %b we %b addr %h want 1 0 004",
                  api_cs, api_we, api_addr);
      end
      tick();
      api_rdata = 32'h0BADF00D;
      tick();
      api_rdata = 32'h0;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'h0BADF00D || rsp_err !== 1'b0) begin
         errors++;
         $display("FAIL b2b_rsp2: got v %b data %h err %b want 1 0badf00d 0",
                  rsp_valid, rsp_data, rsp_err);
      end
      tick();
      rsp_ready = 1'b0;
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_done: got v %b rdy %b want 0 1", rsp_valid, req_ready);
      end
   endtask

   initial begin
      #1;
      test_reset();
      test_write();
      test_read();
      test_unmapped();
      test_stall();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
